// File: rtl/mem_stage.sv
// mem_stage: fourth pipeline stage of the CPU.
// Holds the EX/MEM pipeline register and the word-addressed data memory, and
// resolves conditional branches. It hands the taken-branch target back to IF
// and passes write-back control, ALU result, load data and tags on to WB.
module mem_stage #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [4:0]  ex_destR,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_zero,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_mdata,
  output logic [4:0]  mem_destR,
  output logic        mem_pcsrc,
  output logic [31:0] mem_bpc,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number
);

  localparam int DEPTH = 1 << ADDR_W;

  // EX/MEM pipeline register fields
  logic        wreg_r;
  logic        m2reg_r;
  logic        wmem_r;
  logic [31:0] aluR_r;
  logic [31:0] inB_r;
  logic [4:0]  destR_r;
  logic        branch_r;
  logic [31:0] pc_r;
  logic        zero_r;
  logic [3:0]  ins_type_r;
  logic [3:0]  ins_number_r;

  // Data memory; contents deliberately survive reset
  logic [31:0] dmem_r [DEPTH];

  // Word index: byte offset [1:0] dropped, high bits dropped so addresses wrap
  logic [ADDR_W-1:0] word_idx_s;
  logic              pcsrc_s;

  assign word_idx_s = aluR_r[ADDR_W+1:2];

  // EX/MEM register: no enable, stalls arrive as bubbles; async clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg_r       <= 1'b0;
      m2reg_r      <= 1'b0;
      wmem_r       <= 1'b0;
      aluR_r       <= 32'd0;
      inB_r        <= 32'd0;
      destR_r      <= 5'd0;
      branch_r     <= 1'b0;
      pc_r         <= 32'd0;
      zero_r       <= 1'b0;
      ins_type_r   <= 4'd0;
      ins_number_r <= 4'd0;
    end else begin
      wreg_r       <= ex_wreg;
      m2reg_r      <= ex_m2reg;
      wmem_r       <= ex_wmem;
      aluR_r       <= ex_aluR;
      inB_r        <= ex_inB;
      destR_r      <= ex_destR;
      branch_r     <= ex_branch;
      pc_r         <= ex_pc;
      zero_r       <= ex_zero;
      ins_type_r   <= EXE_ins_type;
      ins_number_r <= EXE_ins_number;
    end
  end

  // Store commits at the edge ending its MEM cycle; wmem_r is cleared during
  // reset, so a store caught by reset never reaches the array
  always_ff @(posedge clk) begin
    if (wmem_r) begin
      dmem_r[word_idx_s] <= inB_r;
    end
  end

  // Branch resolution from registered state only, so the select is glitch-free
  always_comb begin
    pcsrc_s = 1'b0;
    if (branch_r && zero_r) begin
      pcsrc_s = 1'b1;
    end else begin
      pcsrc_s = 1'b0;
    end
  end

  assign mem_wreg       = wreg_r;
  assign mem_m2reg      = m2reg_r;
  assign mem_aluR       = aluR_r;
  assign mem_mdata      = dmem_r[word_idx_s];
  assign mem_destR      = destR_r;
  assign mem_pcsrc      = pcsrc_s;
  assign mem_bpc        = pc_r;
  assign MEM_ins_type   = ins_type_r;
  assign MEM_ins_number = ins_number_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic        ex_wmem;
  logic [31:0] ex_aluR;
  logic [31:0] ex_inB;
  logic [4:0]  ex_destR;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_zero;
  logic [3:0]  EXE_ins_type;
  logic [3:0]  EXE_ins_number;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [31:0] mem_aluR;
  logic [31:0] mem_mdata;
  logic [4:0]  mem_destR;
  logic        mem_pcsrc;
  logic [31:0] mem_bpc;
  logic [3:0]  MEM_ins_type;
  logic [3:0]  MEM_ins_number;

  int checks;
  int errors;

  mem_stage #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_zero(ex_zero),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_aluR(mem_aluR),
    .mem_mdata(mem_mdata), .mem_destR(mem_destR), .mem_pcsrc(mem_pcsrc),
    .mem_bpc(mem_bpc), .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input logic [31:0] a, input logic [31:0] b);
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0; ex_branch = 1'b0;
    ex_zero = 1'b0; ex_aluR = a; ex_inB = b; ex_destR = 5'd0; ex_pc = 32'd0;
    EXE_ins_type = 4'd0; EXE_ins_number = 4'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bubble(a, d);
    ex_wmem = 1'b1;
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    bubble(a, 32'd0);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_destR = rd;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    bubble(32'd0, 32'd0);
    rst_n = 1'b0;
    step(); step();
    checks++;
    got = {mem_wreg, mem_m2reg, mem_pcsrc, mem_destR, MEM_ins_type, MEM_ins_number};
    if (got !== 32'd0 || mem_aluR !== 32'd0 || mem_bpc !== 32'd0) begin
      errors++;
      $display("FAIL reset_init ctrl=%h aluR=%h bpc=%h expected all 0", got, mem_aluR, mem_bpc);
    end
    rst_n = 1'b1;
    // seed word 1 with a known value
    store(32'h4, 32'h1111_1111);
    step();
    bubble(32'h4, 32'd0);
    step();
    checks++;
    if (mem_mdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_seed mdata=%h expected 11111111", mem_mdata);
    end
    // hold reset with a store presented on EX while clock toggles
    store(32'h4, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    step(); step(); step();
    checks++;
    if (mem_wreg !== 1'b0 || mem_m2reg !== 1'b0 || mem_pcsrc !== 1'b0 ||
        mem_aluR !== 32'd0 || mem_bpc !== 32'd0 || mem_destR !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold wreg=%b m2reg=%b pcsrc=%b aluR=%h bpc=%h destR=%0d expected 0",
               mem_wreg, mem_m2reg, mem_pcsrc, mem_aluR, mem_bpc, mem_destR);
    end
    rst_n = 1'b1;
    load(32'h4, 5'd1);
    step();
    checks++;
    if (mem_mdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_no_write mdata=%h expected 11111111", mem_mdata);
    end
    // reset asserted while a store sits in MEM cancels that write
    store(32'h4, 32'hCAFE_F00D);
    step();
    bubble(32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    load(32'h4, 5'd1);
    step();
    checks++;
    if (mem_mdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_mid_store mdata=%h expected 11111111", mem_mdata);
    end
  endtask

  task automatic test_store_load();
    store(32'h8, 32'h1234_5678);
    step();
    load(32'h8, 5'd9);
    step();
    checks++;
    if (mem_mdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_load_data mdata=%h expected 12345678", mem_mdata);
    end
    checks++;
    if (mem_destR !== 5'd9 || mem_wreg !== 1'b1 || mem_m2reg !== 1'b1 || mem_aluR !== 32'h8) begin
      errors++;
      $display("FAIL store_load_ctrl destR=%0d wreg=%b m2reg=%b aluR=%h expected 9 1 1 00000008",
               mem_destR, mem_wreg, mem_m2reg, mem_aluR);
    end
  endtask

  task automatic test_wrap();
    store(32'h0000_0083, 32'hA5A5_A5A5);
    step();
    load(32'h0, 5'd3);
    step();
    checks++;
    if (mem_mdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL addr_wrap mdata=%h expected a5a5a5a5", mem_mdata);
    end
    // high address bits also wrap: 0x88 maps to word 2 (holds 0x12345678)
    load(32'h0000_0088, 5'd3);
    step();
    checks++;
    if (mem_mdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL addr_wrap_high mdata=%h expected 12345678", mem_mdata);
    end
  endtask

  task automatic test_branch();
    bubble(32'd0, 32'd0);
    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 32'h40;
    step();
    checks++;
    if (mem_pcsrc !== 1'b1 || mem_bpc !== 32'h40) begin
      errors++;
      $display("FAIL branch_taken pcsrc=%b bpc=%h expected 1 00000040", mem_pcsrc, mem_bpc);
    end
    bubble(32'd0, 32'd0);
    step();
    checks++;
    if (mem_pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL branch_one_cycle pcsrc=%b expected 0", mem_pcsrc);
    end
    bubble(32'd0, 32'd0);
    ex_branch = 1'b1; ex_zero = 1'b0; ex_pc = 32'h80;
    step();
    checks++;
    if (mem_pcsrc !== 1'b0 || mem_bpc !== 32'h80) begin
      errors++;
      $display("FAIL branch_not_taken pcsrc=%b bpc=%h expected 0 00000080", mem_pcsrc, mem_bpc);
    end
    bubble(32'd0, 32'd0);
    ex_branch = 1'b0; ex_zero = 1'b1; ex_pc = 32'h44;
    step();
    checks++;
    if (mem_pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL branch_zero_only pcsrc=%b expected 0", mem_pcsrc);
    end
  endtask

  task automatic test_bubble();
    bubble(32'h8, 32'hFFFF_FFFF);
    ex_zero = 1'b1; ex_destR = 5'd17; ex_m2reg = 1'b1;
    step();
    checks++;
    if (mem_pcsrc !== 1'b0 || mem_wreg !== 1'b0) begin
      errors++;
      $display("FAIL bubble_ctrl pcsrc=%b wreg=%b expected 0 0", mem_pcsrc, mem_wreg);
    end
    load(32'h8, 5'd4);
    step();
    checks++;
    if (mem_mdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bubble_no_write mdata=%h expected 12345678", mem_mdata);
    end
  endtask

  task automatic test_tags();
    bubble(32'd0, 32'd0);
    EXE_ins_type = 4'd3; EXE_ins_number = 4'd7;
    step();
    checks++;
    if (MEM_ins_type !== 4'd3 || MEM_ins_number !== 4'd7) begin
      errors++;
      $display("FAIL tags_pass type=%0d number=%0d expected 3 7", MEM_ins_type, MEM_ins_number);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (MEM_ins_type !== 4'd0 || MEM_ins_number !== 4'd0) begin
      errors++;
      $display("FAIL tags_async_reset type=%0d number=%0d expected 0 0", MEM_ins_type, MEM_ins_number);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    store(32'h10, 32'h0BAD_F00D);
    step();
    store(32'h14, 32'h600D_CAFE);
    step();
    load(32'h10, 5'd5);
    step();
    checks++;
    if (mem_mdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL b2b_load0 mdata=%h expected 0badf00d", mem_mdata);
    end
    load(32'h14, 5'd6);
    step();
    checks++;
    if (mem_mdata !== 32'h600D_CAFE || mem_destR !== 5'd6) begin
      errors++;
      $display("FAIL b2b_load1 mdata=%h destR=%0d expected 600dcafe 6", mem_mdata, mem_destR);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bubble(32'd0, 32'd0);
    #1;
    test_reset();
    test_store_load();
    test_wrap();
    test_branch();
    test_bubble();
    test_tags();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the pipelined CPU. Consumes the EX-stage outputs through an internal EX/MEM pipeline register.
- Contains the word-addressed data memory and resolves conditional branches.
- Returns the taken-branch target and select to the IF stage.
- Forwards write-back control, ALU result, load data and destination register to the WB stage, with the instruction-tracking tags.

Parameters:
- ADDR_W, 5, log2 of data-memory depth in 32-bit words (default 32 words).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_wreg  input  1  EX: instruction writes register file
- ex_m2reg  input  1  EX: write-back source is memory
- ex_wmem  input  1  EX: store instruction
- ex_aluR  input  32  EX: ALU result / effective address
- ex_inB  input  32  EX: store data
- ex_destR  input  5  EX: destination register number
- ex_branch  input  1  EX: conditional branch instruction
- ex_pc  input  32  EX: computed branch target
- ex_zero  input  1  EX: ALU operands equal
- EXE_ins_type  input  4  EX instruction-type tag
- EXE_ins_number  input  4  EX instruction-number tag
- mem_wreg  output  1  registered wreg to WB
- mem_m2reg  output  1  registered m2reg to WB
- mem_aluR  output  32  registered ALU result
- mem_mdata  output  32  load data read from memory
- mem_destR  output  5  registered destination register
- mem_pcsrc  output  1  branch taken, select mem_bpc in IF
- mem_bpc  output  32  registered branch target
- MEM_ins_type  output  4  registered type tag
- MEM_ins_number  output  4  registered number tag

Behaviour:
- EX/MEM register:
  - On each rising clk, latches every ex_* input and both tags.
  - No enable: a stall in an earlier stage reaches this stage as a bubble, meaning wreg=0, wmem=0 and branch=0 arriving from EX.
- Reset:
  - rst_n low clears all EX/MEM fields to 0 immediately and asynchronously. mem_wreg, mem_m2reg, mem_pcsrc, internal wmem and branch are 0; mem_aluR, mem_bpc and mem_destR are 0; both tags are 0.
  - Memory contents are not reset.
  - No memory write occurs while rst_n is low.
  - Reset asserted mid-store cancels the pending write.
- Memory:
  - 2^ADDR_W x 32-bit array.
  - Word index = latched aluR[ADDR_W+1:2]. Bits [1:0] are ignored. Bits above ADDR_W+1 are ignored, so addresses wrap modulo the depth.
- Read:
  - Combinational from the latched address.
  - mem_mdata is valid in the same cycle the instruction occupies MEM, so load latency is 1 cycle after EX.
  - mem_mdata is driven regardless of mem_m2reg.
- Write:
  - At the rising edge that ends the instruction's MEM cycle, if latched wmem=1, the array at the latched index takes the latched inB.
  - The same edge loads the next instruction into EX/MEM.
  - A load immediately following a store to the same word reads the new data, because the write completes at the same edge the load enters MEM.
  - A store and a load never access the array in the same cycle.
- Branch:
  - mem_pcsrc = latched branch AND latched zero. It is combinational from registered state, so it is glitch-free relative to clk.
  - mem_bpc = latched ex_pc.
  - A branch is taken exactly one cycle: the cycle it resides in MEM.
  - Squashing the younger instructions is done outside this block.
- mem_wreg and mem_m2reg pass through unchanged. The block does not qualify them with the branch outcome.
- Tags pass through with 1-cycle latency.

Test Plan:
- Reset: hold rst_n=0 with ex_wmem=1, ex_aluR=0x4, ex_inB=0xDEADBEEF, toggling clk. Required: all outputs 0 and word 1 unchanged. Release reset, then read word 1: old content returned.
- Store/load: cycle N store ex_aluR=0x8, ex_inB=0x12345678, ex_wmem=1; cycle N+1 load ex_aluR=0x8, ex_m2reg=1, ex_wreg=1, ex_destR=9. Required: in N+2, mem_mdata=0x12345678, mem_destR=9, mem_wreg=1.
- Address wrap and alignment (ADDR_W=5): store 0xA5A5A5A5 at ex_aluR=0x0000_0083. Required: load of ex_aluR=0x0 reads 0xA5A5A5A5, since word index 0 comes from address bits [6:2] and bits above ADDR_W+1 and [1:0] are ignored.
- Branch taken vs not taken:
  - ex_branch=1, ex_zero=1, ex_pc=0x40: mem_pcsrc=1 and mem_bpc=0x40 for exactly one cycle.
  - ex_branch=1, ex_zero=0: mem_pcsrc stays 0.
- Bubble: ex_wmem=0, ex_wreg=0, ex_branch=0 with arbitrary data. Required: no memory change, mem_pcsrc=0, mem_wreg=0.
- Tags: EXE_ins_type=3, EXE_ins_number=7. Required: MEM_ins_type=3, MEM_ins_number=7 one cycle later. Asserting rst_n=0 mid-cycle zeroes both tags immediately.
